// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
// Holds the FSM state encoding, default bus widths and the load/store opcode values.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;

   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping; one-hot grant plus index.
// Purely combinational, no backpressure of its own.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   int               sum;
   logic [PTR_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      sum     = 0;
      idx     = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = int'(ptr) + off;
         if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
         end
         idx = PTR_W'(sum);
         if (!gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory subsystem port between NUM_REQ requesters, round-robin, one op in flight.
// Accept at t, MEM_* from t+1, MEM_DONE at t+k -> response at t+k+1; ready only while idle, responses unthrottled.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [NUM_REQ-1:0]        REQ_VALID,
   output logic [NUM_REQ-1:0]        REQ_READY,
   input  logic [NUM_REQ-1:0]        REQ_STORE,
   input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
   input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
   output logic [NUM_REQ-1:0]        RESP_VALID,
   output logic                      RESP_ERR,
   output logic [DATA_W-1:0]         RESP_RDATA,
   output logic                      MEM_LOAD,
   output logic                      MEM_STORE,
   output logic [ADDR_W-1:0]         MEM_ADDR,
   output logic [DATA_W-1:0]         MEM_WDATA,
   input  logic [DATA_W-1:0]         MEM_RDATA,
   input  logic                      MEM_DONE,
   output logic                      BUSY
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t          state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    owner_q, owner_d;
   logic                store_q, store_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [NUM_REQ-1:0]  resp_vld_q, resp_vld_d;
   logic                resp_err_q, resp_err_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

   logic [NUM_REQ-1:0]  gnt;
   logic [PTR_W-1:0]    gnt_idx;
   logic                gnt_any;
   logic                sel_store;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                timeout_hit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req     (REQ_VALID),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Grant is one-hot, so OR-ing the masked lanes yields the winner's fields.
   always_comb begin
      sel_store = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_store = sel_store | REQ_STORE[i];
            sel_addr  = sel_addr  | REQ_ADDR[i*ADDR_W +: ADDR_W];
            sel_wdata = sel_wdata | REQ_WDATA[i*DATA_W +: DATA_W];
         end
      end
   end

   assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      store_d      = store_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      resp_vld_d   = '0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      REQ_READY    = '0;
      MEM_LOAD     = 1'b0;
      MEM_STORE    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (RST_N && gnt_any) begin
               REQ_READY = gnt;
               owner_d   = gnt_idx;
               store_d   = sel_store;
               addr_d    = sel_addr;
               wdata_d   = sel_wdata;
               ptr_d     = PTR_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            MEM_LOAD  = (store_q == OP_LOAD);
            MEM_STORE = (store_q == OP_STORE);
            cnt_d     = cnt_inc;
            // Completion takes priority over a timeout landing on the same cycle.
            if (MEM_DONE) begin
               resp_vld_d[owner_q] = 1'b1;
               resp_rdata_d        = (store_q == OP_LOAD) ? MEM_RDATA : '0;
               state_d             = ST_GAP;
            end else if (timeout_hit) begin
               resp_vld_d[owner_q] = 1'b1;
               resp_err_d          = 1'b1;
               state_d             = ST_GAP;
            end
         end
         ST_GAP: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         store_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         resp_vld_q   <= '0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         store_q      <= store_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         resp_vld_q   <= resp_vld_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign RESP_VALID = resp_vld_q;
   assign RESP_ERR   = resp_err_q;
   assign RESP_RDATA = resp_rdata_q;
   assign MEM_ADDR   = addr_q;
   assign MEM_WDATA  = wdata_q;
   assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a response scoreboard.
// Expected responses are queued at accept time and checked when RESP_VALID fires.
module tb_mem_req_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [1:0]  req_store = '0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [1:0]  resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_load;
   logic        mem_store;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_done = 1'b0;
   logic        busy;

   always #5 clk = ~clk;

   mem_req_arbiter #(
      .NUM_REQ        (2),
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .REQ_VALID  (req_valid),
      .REQ_READY  (req_ready),
      .REQ_STORE  (req_store),
      .REQ_ADDR   (req_addr),
      .REQ_WDATA  (req_wdata),
      .RESP_VALID (resp_valid),
      .RESP_ERR   (resp_err),
      .RESP_RDATA (resp_rdata),
      .MEM_LOAD   (mem_load),
      .MEM_STORE  (mem_store),
      .MEM_ADDR   (mem_addr),
      .MEM_WDATA  (mem_wdata),
      .MEM_RDATA  (mem_rdata),
      .MEM_DONE   (mem_done),
      .BUSY       (busy)
   );

   typedef struct {
      int          owner;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"},  req_ready,  0);
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_resp_err"},   resp_err,   0);
      check({tag, "_resp_rdata"}, resp_rdata, 0);
      check({tag, "_mem_load"},   mem_load,   0);
      check({tag, "_mem_store"},  mem_store,  0);
      check({tag, "_mem_addr"},   mem_addr,   0);
      check({tag, "_mem_wdata"},  mem_wdata,  0);
      check({tag, "_busy"},       busy,       0);
   endtask

   // Called at posedge+1 of the accept cycle with the request already driven.
   // k = BUSY cycle on which MEM_DONE is pulsed; 0 = never (timeout expected).
   task automatic txn(input int who, input logic st, input logic [31:0] addr,
                      input logic [31:0] wdata, input int k, input logic [31:0] rdata);
      exp_t       e;
      logic [1:0] oh;
      logic       err;
      int         c;
      oh  = (who == 1) ? 2'b10 : 2'b01;
      err = (k == 0);
      @(negedge clk);
      check("accept_ready", req_ready, oh);
      e.owner = who;
      e.err   = err;
      e.rdata = (st || err) ? 32'h0 : rdata;
      sb.push_back(e);
      c = 0;
      do begin
         c++;
         @(posedge clk); #1;
         mem_done  = (c == k);
         mem_rdata = (c == k) ? rdata : 32'h5A5A_5A5A;
         @(negedge clk);
         check("busy_mem_load",  mem_load,  !st);
         check("busy_mem_store", mem_store, st);
         check("busy_mem_addr",  mem_addr,  addr);
         if (st) check("busy_mem_wdata", mem_wdata, wdata);
         check("busy_ready", req_ready, 0);
      end while (c != k && !(k == 0 && c == TO));
      @(posedge clk); #1;
      mem_done = 1'b0;
      @(negedge clk);
      check("resp_valid_latency", resp_valid, oh);
      check("gap_mem_load",  mem_load,  0);
      check("gap_mem_store", mem_store, 0);
      check("gap_ready",     req_ready, 0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && resp_valid != 2'b00) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL resp_unexpected: observed %0h expected none", resp_valid);
         end else begin
            e = sb.pop_front();
            check("resp_owner", resp_valid, (e.owner == 1) ? 2'b10 : 2'b01);
            check("resp_err",   resp_err,   e.err);
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_ready_overlap", resp_valid & req_ready, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish by 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset mid-BUSY drops the transaction.
      req_valid = 2'b01; req_store = 2'b00; req_addr[31:0] = 32'h100;
      @(negedge clk);
      check("t1_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("t1_mem_load", mem_load, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("t1_after_rst");

      // Both requesters valid continuously: grants alternate 0,1,0,1.
      @(posedge clk); #1;
      req_valid = 2'b11; req_store = 2'b01;
      req_addr  = {32'h20, 32'h10};
      req_wdata = {32'h2222_0000, 32'h1111_0000};
      txn(0, 1'b1, 32'h10, 32'h1111_0000, 2, 32'hFFFF_0000);
      txn(1, 1'b0, 32'h20, 32'h2222_0000, 1, 32'hA5A5_0001);
      txn(0, 1'b1, 32'h10, 32'h1111_0000, 3, 32'hFFFF_0001);
      txn(1, 1'b0, 32'h20, 32'h2222_0000, 2, 32'hA5A5_0002);
      req_valid = 2'b00;

      // Lone load, MEM_DONE on the 3rd BUSY cycle.
      req_valid = 2'b01; req_store = 2'b00; req_addr[31:0] = 32'h100;
      txn(0, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
      req_valid = 2'b00;

      // Store from requester 1; response data must be zero.
      req_valid = 2'b10; req_store = 2'b10;
      req_addr[63:32] = 32'h40; req_wdata[63:32] = 32'hCAFE_0001;
      txn(1, 1'b1, 32'h40, 32'hCAFE_0001, 2, 32'hFFFF_0000);
      req_valid = 2'b00;

      // Timeout: requester 1 granted alone while the pointer sits at 0.
      req_valid = 2'b10; req_store = 2'b00; req_addr[63:32] = 32'h80;
      txn(1, 1'b0, 32'h80, 32'h0, 0, 32'h0);
      req_valid = 2'b00;
      @(negedge clk);
      check("t5_idle_after_timeout", busy, 0);

      // MEM_DONE while idle is ignored.
      @(posedge clk); #1;
      mem_done = 1'b1; mem_rdata = 32'h7777_7777;
      @(negedge clk);
      check("t6_idle_done_busy", busy, 0);
      @(posedge clk); #1;
      mem_done = 1'b0;
      @(negedge clk);
      check("t6_idle_done_resp", resp_valid, 0);
      check("t6_idle_done_busy2", busy, 0);

      // MEM_DONE coincident with the timeout cycle gives a normal response.
      @(posedge clk); #1;
      req_valid = 2'b01; req_store = 2'b00; req_addr[31:0] = 32'h200;
      txn(0, 1'b0, 32'h200, 32'h0, TO, 32'h0BAD_F00D);
      req_valid = 2'b00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
